mc_control_fsm: RTL

Parametrised multicycle RISC-V main control FSM, successor to the fixed-latency controller. It sequences fetch, decode, execute, memory and writeback for RV32I base opcodes, and drives the datapath mux selects and write enables. New over the previous generation: memory wait-state handshake, illegal-opcode detection with an optional halting trap state, and an instruction-retired counter. It sits beside the ALU decoder (driven by DecOp) and the branch logic (driven by Branch/PCUpdate) in the multicycle core.

---
 rtl/mc_control_fsm.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, with memory wait states, illegal-opcode trap and retire counting.
module mc_control_fsm #(
    parameter int INSTRET_W       = 32,
    parameter bit USE_MEM_READY   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic [6:0]           op,
    input  logic                 MemReady,
    output logic                 Branch,
    output logic                 PCUpdate,
    output logic                 RegWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           DecOp,
    output logic                 MemReq,
    output logic                 Illegal,
    output logic                 Halted,
    output logic                 Retire,
    output logic [INSTRET_W-1:0] InstRet,
    output logic [3:0]           State
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        LUI      = 4'd10,
        EXECPC   = 4'd11,
        JUMPREG  = 4'd12,
        BRANCH   = 4'd13,
        TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BRAN  = 7'b1100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t               state;
    state_t               next;
    logic                 ready;
    logic                 live;
    logic [13:0]          ctrl;
    logic [INSTRET_W-1:0] instret;

    assign ready = USE_MEM_READY ? MemReady : 1'b1;

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    if (ready) next = DECODE; else next = FETCH;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next = MEMADR;
                    OP_RTYPE:          next = EXECR;
                    OP_ITYPE:          next = EXECI;
                    OP_JAL:            next = JAL;
                    OP_LUI:            next = LUI;
                    OP_JALR:           next = EXECPC;
                    OP_BRAN:           next = BRANCH;
                    OP_AUIPC:          next = ALUWB;
                    default:           if (TRAP_ON_ILLEGAL) next = TRAP; else next = FETCH;
                endcase
            end
            MEMADR:   if (op == OP_LOAD) next = MEMREAD; else next = MEMWRITE;
            MEMREAD:  if (ready) next = MEMWB; else next = MEMREAD;
            MEMWRITE: if (ready) next = FETCH; else next = MEMWRITE;
            EXECR, EXECI, JAL, JUMPREG: next = ALUWB;
            EXECPC:   next = JUMPREG;
            TRAP:     next = TRAP;
            default:  next = FETCH;
        endcase
    end

    // Control word: Branch,PCUpdate,ResultSrc,ALUSrcA,ALUSrcB,RegWrite,AdrSrc,MemWrite,IRWrite,DecOp
    always_comb begin
        ctrl    = '0;
        MemReq  = 1'b0;
        live    = 1'b1;
        Illegal = 1'b0;
        case (state)
            FETCH: begin
                ctrl   = {1'b0, ready, 2'b10, 2'b00, 2'b10, 3'b000, ready, 2'b10};
                MemReq = 1'b1;
            end
            DECODE: begin
                ctrl = 14'b0_0_00_01_01_0_0_0_0_10;
                case (op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL,
                    OP_LUI, OP_JALR, OP_BRAN, OP_AUIPC: Illegal = 1'b0;
                    default:                            Illegal = 1'b1;
                endcase
            end
            MEMADR:  ctrl = 14'b0_0_00_10_01_0_0_0_0_10;
            MEMREAD: begin
                ctrl   = 14'b0_0_00_00_00_0_1_0_0_00;
                MemReq = 1'b1;
            end
            MEMWB:   ctrl = 14'b0_0_01_00_00_1_0_0_0_00;
            MEMWRITE: begin
                ctrl   = {8'b0000_0000, 1'b0, 1'b1, ready, 1'b0, 2'b00};
                MemReq = 1'b1;
            end
            EXECR:        ctrl = 14'b0_0_00_10_00_0_0_0_0_11;
            ALUWB:        ctrl = 14'b0_0_00_00_00_1_0_0_0_10;
            EXECI:        ctrl = 14'b0_0_00_10_01_0_0_0_0_11;
            JAL, JUMPREG: ctrl = 14'b0_1_00_01_10_0_0_0_0_10;
            LUI:          ctrl = 14'b0_0_11_00_00_1_0_0_0_10;
            EXECPC:       ctrl = 14'b0_0_00_10_01_0_0_0_0_10;
            BRANCH:       ctrl = 14'b1_0_00_10_00_0_0_0_0_01;
            TRAP:         ctrl = '0;
            default:      live = 1'b0;
        endcase
    end

    assign {Branch, PCUpdate, ResultSrc, ALUSrcA, ALUSrcB,
            RegWrite, AdrSrc, MemWrite, IRWrite, DecOp} = ctrl;

    // An illegal op falling back to FETCH is a discard, not a completed instruction.
    assign Retire  = live && (next == FETCH) && (state != FETCH) && (state != TRAP) && !Illegal;
    assign Halted  = (state == TRAP);
    assign State   = state;
    assign InstRet = instret;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state <= next;
            if (Retire) instret <= instret + INSTRET_W'(1);
        end
    end
endmodule
